ex_muldiv_unit: RTL and testbench

- Iterative multiply/divide execute unit for the RV32M operations.
- Sits directly downstream of the ID/EX pipeline register, beside the ALU.
- Consumes the registered ALU operands, control code and destination register address from ID/EX.
- Holds the pipeline through stall_req until the result is ready, then presents the result to the EX/MEM path for one cycle.

---
 rtl/ex_muldiv_unit.sv | 216 +++++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide beside the ALU (radix-2 shift-add multiply, restoring divide).
// Latency: result_valid is high after edge XLEN+2 counting the start edge as 1; with MULDIV_FASTPATH_EN, trivial cases finish after edge 1.
// Backpressure: none accepted downstream; holds IF/ID/EX via stall_req until the one-cycle result_valid pulse.
module ex_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic [4:0]      rd_address_in,
    input  logic            flush,
    output logic            stall_req,
    output logic            busy,
    output logic            result_valid,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_address_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       op_q;
    logic [4:0]       rd_q;
    logic             a_neg_q;
    logic             b_neg_q;
    logic [XLEN-1:0]  a_mag_q;
    logic [XLEN-1:0]  b_mag_q;
    // hi_q/lo_q: product {hi,lo} for multiply; remainder (hi) and dividend/quotient shift register (lo) for divide
    logic [XLEN-1:0]  hi_q;
    logic [XLEN-1:0]  lo_q;
    logic [XLEN-1:0]  result_q;
    logic [4:0]       rd_out_q;
    logic             valid_q;

    logic             a_signed;
    logic             b_signed;
    logic             a_neg_d;
    logic             b_neg_d;
    logic [XLEN-1:0]  a_mag_d;
    logic [XLEN-1:0]  b_mag_d;

    // Decode operand signedness from funct3 and take magnitudes at issue time
    always_comb begin
        a_signed = (op == OP_MUL) | (op == OP_MULH) | (op == OP_MULHSU) |
                   (op == OP_DIV) | (op == OP_REM);
        b_signed = (op == OP_MUL) | (op == OP_MULH) | (op == OP_DIV) | (op == OP_REM);
        a_neg_d  = a_signed & operand_a[XLEN-1];
        b_neg_d  = b_signed & operand_b[XLEN-1];
        a_mag_d  = a_neg_d ? ('0 - operand_a) : operand_a;
        b_mag_d  = b_neg_d ? ('0 - operand_b) : operand_b;
    end

    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_tmp;
    logic [XLEN-1:0] div_diff;
    logic            div_ge;
    logic [XLEN-1:0] hi_d;
    logic [XLEN-1:0] lo_d;

    // One radix-2 iteration: shift-add for multiply, restoring subtract for divide
    always_comb begin
        mul_sum  = {1'b0, hi_q} + {1'b0, a_mag_q & {XLEN{lo_q[0]}}};
        div_tmp  = {hi_q, lo_q[XLEN-1]};
        div_ge   = (div_tmp >= {1'b0, b_mag_q});
        // div_tmp < 2*divisor whenever it is subtracted, so the difference fits XLEN bits
        div_diff = div_tmp[XLEN-1:0] - b_mag_q;
        if (op_q[2]) begin
            hi_d = div_ge ? div_diff : div_tmp[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], div_ge};
        end else begin
            hi_d = mul_sum[XLEN:1];
            lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end
    end

    logic [2*XLEN-1:0] prod_raw;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   fix_res;

    // Sign correction and word select; a zero divisor keeps the all-ones quotient unsigned-looking
    always_comb begin
        prod_raw = {hi_q, lo_q};
        prod_fix = (a_neg_q ^ b_neg_q) ? ('0 - prod_raw) : prod_raw;
        quo_fix  = ((a_neg_q ^ b_neg_q) && (b_mag_q != '0)) ? ('0 - lo_q) : lo_q;
        rem_fix  = a_neg_q ? ('0 - hi_q) : hi_q;
        fix_res  = rem_fix;
        case (op_q)
            OP_MUL:                       fix_res = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fix_res = quo_fix;
            default:                      fix_res = rem_fix;
        endcase
    end

`ifdef MULDIV_FASTPATH_EN
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic            fast_hit;
    logic [XLEN-1:0] fast_res;

    // Detect operations whose result is known from the raw operands alone
    always_comb begin
        fast_hit = 1'b0;
        fast_res = '0;
        if (op[2]) begin
            if (operand_b == '0) begin
                fast_hit = 1'b1;
                fast_res = op[1] ? operand_a : '1;
            end else if (!op[0] && (operand_a == MIN_NEG) && (operand_b == '1)) begin
                fast_hit = 1'b1;
                fast_res = op[1] ? '0 : MIN_NEG;
            end
        end else if ((operand_a == '0) || (operand_b == '0)) begin
            fast_hit = 1'b1;
            fast_res = '0;
        end
    end
`endif

    // Control FSM and datapath registers; flush aborts without touching result/rd_address_out
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            a_mag_q  <= '0;
            b_mag_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
            rd_out_q <= '0;
            valid_q  <= 1'b0;
        end else if (flush) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    valid_q <= 1'b0;
                    if (start) begin
                        op_q    <= op;
                        rd_q    <= rd_address_in;
                        a_neg_q <= a_neg_d;
                        b_neg_q <= b_neg_d;
                        a_mag_q <= a_mag_d;
                        b_mag_q <= b_mag_d;
                        hi_q    <= '0;
                        lo_q    <= op[2] ? a_mag_d : b_mag_d;
                        cnt_q   <= '0;
                        state_q <= S_CALC;
`ifdef MULDIV_FASTPATH_EN
                        if (fast_hit) begin
                            result_q <= fast_res;
                            rd_out_q <= rd_address_in;
                            valid_q  <= 1'b1;
                            state_q  <= S_DONE;
                        end
`endif
                    end
                end
                S_CALC: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    result_q <= fix_res;
                    rd_out_q <= rd_q;
                    valid_q  <= 1'b1;
                    state_q  <= S_DONE;
                end
                default: begin
                    // DONE: ID/EX still shows the same instruction, so start is ignored here
                    valid_q <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign stall_req      = ((state_q == S_IDLE) & start & ~flush) |
                            (state_q == S_CALC) | (state_q == S_FIX);
    assign busy           = (state_q != S_IDLE);
    assign result_valid   = valid_q;
    assign result         = result_q;
    assign rd_address_out = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed RV32M vectors against a scoreboard of hand-computed results.
// Latency: expected completion edge is stored with each entry (34, or 1 for fast-path cases when enabled).
// Backpressure: the driver holds start high until result_valid, like a stalled ID/EX register.
module tb_ex_muldiv_unit;

`ifdef MULDIV_FASTPATH_EN
    localparam bit FAST_EN = 1'b1;
`else
    localparam bit FAST_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [2:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [4:0]  rd_address_in;
    logic        flush;
    logic        stall_req;
    logic        busy;
    logic        result_valid;
    logic [31:0] result;
    logic [4:0]  rd_address_out;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          edge_n;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [31:0] last_res = '0;
    logic [4:0]  last_rd  = '0;

    ex_muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .start          (start),
        .op             (op),
        .operand_a      (operand_a),
        .operand_b      (operand_b),
        .rd_address_in  (rd_address_in),
        .flush          (flush),
        .stall_req      (stall_req),
        .busy           (busy),
        .result_valid   (result_valid),
        .result         (result),
        .rd_address_out (rd_address_out)
    );

    always #5 clk = ~clk;

    // Edge counter: at a negedge, cyc equals the number of posedges so far
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every result_valid pulse must match the oldest outstanding request
    always @(negedge clk) begin
        if (result_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: actual=%h required=no result_valid (edge %0d)", result, cyc);
            end else begin
                mon_e = sb_q.pop_front();
                chk("result", result, mon_e.res);
                chk("rd_address_out", {27'b0, rd_address_out}, {27'b0, mon_e.rd});
                chk("valid_edge", cyc, mon_e.edge_n);
            end
        end
    end

    // Issue one op, hold start until result_valid, check stall/busy along the way
    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp_res, input bit fast);
        exp_t e;
        int   lat;
        bit   got;
        lat = 34;
        if (FAST_EN && fast) lat = 1;
        @(negedge clk);
        op            = o;
        operand_a     = a;
        operand_b     = b;
        rd_address_in = rd;
        start         = 1'b1;
        e.res    = exp_res;
        e.rd     = rd;
        e.edge_n = cyc + lat;
        sb_q.push_back(e);
        #1;
        chk({name, "_stall_start"}, {31'b0, stall_req}, 32'd1);
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (result_valid === 1'b1) begin
                got = 1'b1;
                chk({name, "_stall_done"}, {31'b0, stall_req}, 32'd0);
                chk({name, "_busy_done"}, {31'b0, busy}, 32'd1);
            end else begin
                chk({name, "_stall_wait"}, {31'b0, stall_req}, 32'd1);
            end
        end
        start = 1'b0;
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: actual=no result_valid required=result_valid within 60 cycles", name);
            void'(sb_q.pop_back());
        end
        @(negedge clk);
        chk({name, "_idle_busy"}, {31'b0, busy}, 32'd0);
        last_res = exp_res;
        last_rd  = rd;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=still running required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn        = 1'b0;
        start         = 1'b0;
        flush         = 1'b0;
        op            = '0;
        operand_a     = '0;
        operand_b     = '0;
        rd_address_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_result", result, 32'h0);
        chk("rst_rd", {27'b0, rd_address_out}, 32'h0);
        chk("rst_valid", {31'b0, result_valid}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_stall", {31'b0, stall_req}, 32'h0);
        resetn = 1'b1;

        // Multiply family
        run_op("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 1'b0);
        run_op("mulh",   3'b001, 32'h80000000, 32'h80000000, 5'd6,  32'h40000000, 1'b0);
        run_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE, 1'b0);
        run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFF, 1'b0);
        run_op("mul0",   3'b000, 32'd0,        32'd5,        5'd9,  32'h0,        1'b1);

        // Divide family
        run_op("div",    3'b100, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFD, 1'b0);
        run_op("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        5'd11, 32'hFFFFFFFF, 1'b0);
        run_op("divu",   3'b101, 32'd100,      32'd7,        5'd17, 32'd14,       1'b0);
        run_op("remu",   3'b111, 32'd100,      32'd7,        5'd18, 32'd2,        1'b0);

        // Divide by zero and signed overflow
        run_op("divu0",  3'b101, 32'd5,        32'd0,        5'd19, 32'hFFFFFFFF, 1'b1);
        run_op("remu0",  3'b111, 32'd5,        32'd0,        5'd20, 32'd5,        1'b1);
        run_op("divneg0",3'b100, 32'hFFFFFFF9, 32'd0,        5'd21, 32'hFFFFFFFF, 1'b1);
        run_op("remneg0",3'b110, 32'hFFFFFFF9, 32'd0,        5'd22, 32'hFFFFFFF9, 1'b1);
        run_op("divovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd23, 32'h80000000, 1'b1);
        run_op("removf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd24, 32'h0,        1'b1);

        // Flush a DIV mid-calculation: no result, outputs keep previous values
        @(negedge clk);
        op = 3'b100; operand_a = 32'd1000; operand_b = 32'd3; rd_address_in = 5'd30;
        start = 1'b1;
        repeat (10) @(negedge clk);
        chk("flush_busy_before", {31'b0, busy}, 32'd1);
        flush = 1'b1;
        start = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", {31'b0, busy}, 32'd0);
        chk("flush_valid", {31'b0, result_valid}, 32'd0);
        chk("flush_stall", {31'b0, stall_req}, 32'd0);
        chk("flush_result_hold", result, last_res);
        chk("flush_rd_hold", {27'b0, rd_address_out}, {27'b0, last_rd});
        run_op("mul_after_flush", 3'b000, 32'd3, 32'd4, 5'd12, 32'd12, 1'b0);

        // Reset during an active DIV
        @(negedge clk);
        op = 3'b100; operand_a = 32'd1000; operand_b = 32'd3; rd_address_in = 5'd31;
        start = 1'b1;
        repeat (19) @(negedge clk);
        resetn = 1'b0;
        start  = 1'b0;
        @(negedge clk);
        chk("midrst_result", result, 32'h0);
        chk("midrst_rd", {27'b0, rd_address_out}, 32'h0);
        chk("midrst_valid", {31'b0, result_valid}, 32'h0);
        chk("midrst_busy", {31'b0, busy}, 32'h0);
        chk("midrst_stall", {31'b0, stall_req}, 32'h0);
        resetn = 1'b1;
        repeat (40) @(negedge clk);
        run_op("divu_after_rst", 3'b101, 32'd100, 32'd7, 5'd3, 32'd14, 1'b0);

        repeat (5) @(negedge clk);
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
